start_token_fifo_ctrl: RTL and testbench

- Control and storage wrapper for the shift-register FIFO that carries start tokens (and small data words) between HLS dataflow processes. Example: the producer stage's ap_start handshake to a downstream PE_i4xi4 instance.
- Contains an addressed shift-register storage array, an occupancy pointer, full/empty flag generation and the producer/consumer handshakes.
- Sits directly upstream of the consuming process's start/ready logic and downstream of the producing process's done/continue logic.

---
 rtl/start_token_fifo_ctrl.sv | 85 ++++++++
 tb/tb_start_token_fifo_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/start_token_fifo_ctrl.sv
// Shift-register FIFO carrying start tokens / small words between dataflow processes.
// Registered occupancy and flags; head word read combinationally from the registered address.
module start_token_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned AF_LEVEL   = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_count
);

    localparam int unsigned CW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  empty_n_nxt;
    logic                  full_n_nxt;
    logic                  af_nxt;
    logic                  push;
    logic                  pop;

    // Blocked requests collapse here: full blocks push, empty blocks pop.
    assign push = if_write & if_write_ce & if_full_n;
    assign pop  = if_read  & if_read_ce  & if_empty_n;

    // Storage: no reset; new word enters slot 0, older words move one slot deeper.
    always_ff @(posedge ap_clk) begin
        if (push) mem[0] <= if_din;
    end

    for (genvar g = 1; g < DEPTH; g++) begin : g_shift
        always_ff @(posedge ap_clk) begin
            if (push) mem[g] <= mem[g-1];
        end
    end

    assign if_dout = mem[addr];

    // Next occupancy, head address and flags.
    always_comb begin
        count_nxt = count;
        unique case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
        addr_nxt    = (count_nxt == CW'(0)) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(count_nxt - CW'(1));
        empty_n_nxt = (count_nxt != CW'(0));
        full_n_nxt  = (count_nxt != CW'(DEPTH));
        af_nxt      = (count_nxt >= CW'(AF_LEVEL));
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            count          <= '0;
            addr           <= '0;
            if_empty_n     <= 1'b0;
            if_full_n      <= 1'b1;
            if_almost_full <= 1'b0;
        end else begin
            count          <= count_nxt;
            addr           <= addr_nxt;
            if_empty_n     <= empty_n_nxt;
            if_full_n      <= full_n_nxt;
            if_almost_full <= af_nxt;
        end
    end

    assign if_count = count;

endmodule

// File: tb/tb_start_token_fifo_ctrl.sv
// Directed bench for start_token_fifo_ctrl at DEPTH=4, AF_LEVEL=3, 8-bit data.
module tb_start_token_fifo_ctrl;

    logic       ap_clk = 1'b0;
    logic       ap_rst_n;
    logic       if_write_ce, if_write, if_read_ce, if_read;
    logic [7:0] if_din;
    logic       if_full_n, if_almost_full, if_empty_n;
    logic [7:0] if_dout;
    logic [2:0] if_count;

    int vectors = 0;
    int errors  = 0;

    start_token_fifo_ctrl #(
        .DATA_WIDTH(8), .ADDR_WIDTH(2), .DEPTH(4), .AF_LEVEL(3)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
        .if_full_n(if_full_n), .if_almost_full(if_almost_full),
        .if_read_ce(if_read_ce), .if_read(if_read),
        .if_dout(if_dout), .if_empty_n(if_empty_n), .if_count(if_count)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given request pattern; returns #1 after the edge with requests idle.
    task automatic op(input logic w, input logic wce, input logic r, input logic rce, input logic [7:0] d);
        if_write = w; if_write_ce = wce; if_read = r; if_read_ce = rce; if_din = d;
        @(posedge ap_clk); #1;
        if_write = 1'b0; if_write_ce = 1'b0; if_read = 1'b0; if_read_ce = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        op(1'b1, 1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic pop();
        op(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    endtask

    task automatic check_flags(input string tag, input int cnt, input logic e_n,
                               input logic f_n, input logic af);
        check({tag, ".count"},   32'(if_count),       32'(cnt));
        check({tag, ".empty_n"}, 32'(if_empty_n),     32'(e_n));
        check({tag, ".full_n"},  32'(if_full_n),      32'(f_n));
        check({tag, ".af"},      32'(if_almost_full), 32'(af));
    endtask

    initial begin
        ap_rst_n = 1'b0;
        if_write = 1'b0; if_write_ce = 1'b0; if_read = 1'b0; if_read_ce = 1'b0; if_din = 8'h00;
        repeat (3) @(posedge ap_clk);
        #1;
        check_flags("reset", 0, 1'b0, 1'b1, 1'b0);

        // First push on the first edge after release.
        ap_rst_n = 1'b1;
        push(8'hA1);
        check_flags("first_push", 1, 1'b1, 1'b1, 1'b0);
        check("first_push.dout", 32'(if_dout), 32'hA1);
        pop();
        check_flags("first_pop", 0, 1'b0, 1'b1, 1'b0);

        // Fill, overflow attempt, drain.
        push(8'h11); check_flags("fill1", 1, 1'b1, 1'b1, 1'b0);
        push(8'h22); check_flags("fill2", 2, 1'b1, 1'b1, 1'b0);
        push(8'h33); check_flags("fill3", 3, 1'b1, 1'b1, 1'b1);
        push(8'h44); check_flags("fill4", 4, 1'b1, 1'b0, 1'b1);
        check("fill4.dout", 32'(if_dout), 32'h11);
        push(8'h55); check_flags("overflow", 4, 1'b1, 1'b0, 1'b1);
        check("overflow.dout", 32'(if_dout), 32'h11);
        begin
            logic [7:0] exp_q [4];
            exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
            for (int i = 0; i < 4; i++) begin
                check($sformatf("drain%0d.dout", i), 32'(if_dout), 32'(exp_q[i]));
                pop();
                check($sformatf("drain%0d.count", i), 32'(if_count), 32'(3 - i));
            end
        end
        check_flags("drained", 0, 1'b0, 1'b1, 1'b0);

        // Simultaneous push and pop keeps count, advances head.
        push(8'h11); push(8'h22);
        op(1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
        check_flags("simul", 2, 1'b1, 1'b1, 1'b0);
        check("simul.dout", 32'(if_dout), 32'h22);
        pop();
        check("simul_pop1.dout", 32'(if_dout), 32'h33);
        check("simul_pop1.count", 32'(if_count), 32'd1);
        pop();
        check_flags("simul_empty", 0, 1'b0, 1'b1, 1'b0);

        // Full with both requests: pop only.
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        op(1'b1, 1'b1, 1'b1, 1'b1, 8'h66);
        check_flags("full_both", 3, 1'b1, 1'b1, 1'b1);
        check("full_both.dout", 32'(if_dout), 32'h22);
        pop(); check("full_both.d2", 32'(if_dout), 32'h33);
        pop(); check("full_both.d3", 32'(if_dout), 32'h44);
        pop(); check_flags("full_both_drained", 0, 1'b0, 1'b1, 1'b0);

        // Empty with both requests: push only.
        op(1'b1, 1'b1, 1'b1, 1'b1, 8'h77);
        check_flags("empty_both", 1, 1'b1, 1'b1, 1'b0);
        check("empty_both.dout", 32'(if_dout), 32'h77);

        // Asynchronous reset between edges with three words queued.
        push(8'h88); push(8'h99);
        check_flags("pre_rst", 3, 1'b1, 1'b1, 1'b1);
        #3 ap_rst_n = 1'b0;
        #1;
        check_flags("async_rst", 0, 1'b0, 1'b1, 1'b0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;

        // Clock-enable gating on both sides.
        op(1'b1, 1'b0, 1'b0, 1'b0, 8'hBB);
        check_flags("wce_gate", 0, 1'b0, 1'b1, 1'b0);
        push(8'hCC);
        check("wce_on.count", 32'(if_count), 32'd1);
        check("wce_on.dout", 32'(if_dout), 32'h CC);
        op(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("rce_gate.count", 32'(if_count), 32'd1);
        pop();
        check_flags("rce_on", 0, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
